cronometru_control: RTL

CRONOMETRU_CONTROL -- requirements
Module: cronometru_control

---
 rtl/cronometru_control.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cronometru_control.sv
// Stopwatch controller: debounced start/stop and lap/clear buttons drive a
// four-state FSM that gates a 1 Hz prescaler and selects live or lap time for display.
module cronometru_control #(
    parameter int CLK_DIV    = 100000000,
    parameter int DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_ss,
    input  logic        btn_lc,
    input  logic [15:0] live_time,
    output logic        tick,
    output logic        pauza,
    output logic        clr,
    output logic [15:0] disp_time,
    output logic [1:0]  state
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    // Index 0 is start/stop, index 1 is lap/clear.
    logic [1:0]    btn;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    ev;
    logic [DW-1:0] deb_cnt [2];

    assign btn = {btn_lc, btn_ss};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            ev         <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                ev[i] <= 1'b0;
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                        ev[i]      <= sync2[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    state_t        st;
    state_t        nxt;
    logic          clr_nxt;
    logic          cap;
    logic          counting;
    logic [PW-1:0] presc;
    logic [15:0]   lap;

    // Start/stop has priority when both events land in the same cycle.
    always_comb begin
        nxt     = st;
        clr_nxt = 1'b0;
        cap     = 1'b0;
        case (st)
            IDLE: begin
                if (ev[0])      nxt = RUN;
                else if (ev[1]) clr_nxt = 1'b1;
            end
            RUN: begin
                if (ev[0]) begin
                    nxt = PAUSE;
                end else if (ev[1]) begin
                    nxt = LAP;
                    cap = 1'b1;
                end
            end
            LAP: begin
                if (ev[0])      nxt = PAUSE;
                else if (ev[1]) nxt = RUN;
            end
            PAUSE: begin
                if (ev[0]) begin
                    nxt = RUN;
                end else if (ev[1]) begin
                    nxt     = IDLE;
                    clr_nxt = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign counting = (nxt == RUN) || (nxt == LAP);
    assign state    = st;

    // Prescaler holds in PAUSE so a resumed run keeps its partial second.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            pauza     <= 1'b1;
            clr       <= 1'b0;
            tick      <= 1'b0;
            disp_time <= '0;
            lap       <= '0;
            presc     <= '0;
        end else begin
            st    <= nxt;
            pauza <= !counting;
            clr   <= clr_nxt;
            tick  <= 1'b0;
            if (cap) lap <= live_time;
            disp_time <= (nxt == LAP && !cap) ? lap : live_time;
            if (st == IDLE || clr_nxt) begin
                presc <= '0;
            end else if (counting) begin
                if (presc == PRE_LAST) begin
                    presc <= '0;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule
